// File: rtl/sram_like_resp.sv
// Target end of the sram-like split-transaction bus: accepts address-phase
// handshakes, performs each access on a word memory, returns in-order completions.
module sram_like_resp #(
    parameter int MEM_AW = 10,
    parameter int LAT    = 2,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        addr_hold,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    // The entry is first examined the cycle after acceptance, so one cycle of
    // the latency is already spent when it lands in the queue.
    localparam logic [3:0] LOAD_CD = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

    typedef struct packed {
        logic        is_write;
        logic [31:0] data;
        logic [3:0]  cd;
    } entry_t;

    logic [31:0]          mem [(1 << MEM_AW)];
    entry_t [DEPTH-1:0]   q;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;
    logic [MEM_AW-1:0]    widx;
    logic [31:0]          rd_word;
    logic [31:0]          wr_word;
    entry_t               head;
    logic                 accept;
    logic                 pop;
    logic                 bypass;
    logic                 push;
    logic                 unused_bits;

    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    always_comb begin
        widx    = addr[MEM_AW+1:2];
        rd_word = mem[widx];
        wr_word = rd_word;
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) wr_word[8*b +: 8] = wdata[8*b +: 8];
        head    = q[rd_ptr];
        addr_ok = !reset && !addr_hold && (count < FULL);
        accept  = req && addr_ok;
        pop     = (count != '0) && (head.cd == 4'd0);
        // With LAT=1 an access into an empty queue must complete straight away.
        bypass  = (LAT == 1) && accept && (count == '0);
        push    = accept && !bypass;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
        end else begin
            data_ok <= pop || bypass;
            if (pop)
                rdata <= head.is_write ? 32'd0 : head.data;
            else if (bypass)
                rdata <= wr ? 32'd0 : rd_word;
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // NOTE: memory and queue payload take no reset; validity lives in count and
    // the pointers, and memory contents must survive a reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (q[i].cd != 4'd0) q[i].cd <= q[i].cd - 4'd1;
        if (push)
            q[wr_ptr] <= '{is_write: wr, data: rd_word, cd: LOAD_CD};
        if (accept && wr)
            mem[widx] <= wr_word;
    end
endmodule

// File: tb/tb_sram_like_resp.sv
// Self-checking bench for sram_like_resp: three instances (LAT 2, 1, 8), a
// due-time reference model, directed tables/sequences and randomized traffic.
module tb_sram_like_resp;
    logic        clk = 1'b0;
    logic        rst_v   [3];
    logic        req_v   [3];
    logic        wr_v    [3];
    logic [1:0]  size_v  [3];
    logic [31:0] addr_v  [3];
    logic [3:0]  wstrb_v [3];
    logic [31:0] wdata_v [3];
    logic        hold_v  [3];
    logic        ok_v    [3];
    logic        dok_v   [3];
    logic [31:0] rdata_v [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: expected completions as (due cycle, data).
    logic [31:0] mdl_mem [3][1024];
    int          q_due   [3][64];
    logic [31:0] q_dat   [3][64];
    int          hd [3];
    int          tl [3];
    int          last_due [3];
    logic [31:0] last_rd [3];
    logic        live [3];
    int          dok_cnt [3];
    int          acc_log [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_resp #(.MEM_AW(10), .LAT(2), .DEPTH(4)) u_lat2 (
        .clk(clk), .reset(rst_v[0]), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]),
        .addr(addr_v[0]), .wstrb(wstrb_v[0]), .wdata(wdata_v[0]), .addr_hold(hold_v[0]),
        .addr_ok(ok_v[0]), .data_ok(dok_v[0]), .rdata(rdata_v[0]));
    sram_like_resp #(.MEM_AW(10), .LAT(1), .DEPTH(4)) u_lat1 (
        .clk(clk), .reset(rst_v[1]), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]),
        .addr(addr_v[1]), .wstrb(wstrb_v[1]), .wdata(wdata_v[1]), .addr_hold(hold_v[1]),
        .addr_ok(ok_v[1]), .data_ok(dok_v[1]), .rdata(rdata_v[1]));
    sram_like_resp #(.MEM_AW(10), .LAT(8), .DEPTH(4)) u_lat8 (
        .clk(clk), .reset(rst_v[2]), .req(req_v[2]), .wr(wr_v[2]), .size(size_v[2]),
        .addr(addr_v[2]), .wstrb(wstrb_v[2]), .wdata(wdata_v[2]), .addr_hold(hold_v[2]),
        .addr_ok(ok_v[2]), .data_ok(dok_v[2]), .rdata(rdata_v[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d] cyc=%0d: got %h expected %h", name, idx, cyc, act, exp);
        end
    endtask

    // Reference model: completion i is due at max(accept+LAT, previous due+1);
    // a request stays outstanding until the cycle its data_ok is seen.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic        exp_ok;
            logic [31:0] dat;
            logic [9:0]  w;
            int          dd;
            exp_ok = 1'b0;
            if (dok_v[k] === 1'b1) dok_cnt[k]++;
            if (live[k]) begin
                if (hd[k] != tl[k] && q_due[k][hd[k] % 64] == cyc) begin
                    check("data_ok", k, {31'd0, dok_v[k]}, 32'd1);
                    check("rdata", k, rdata_v[k], q_dat[k][hd[k] % 64]);
                    last_rd[k] = q_dat[k][hd[k] % 64];
                    hd[k]++;
                end else begin
                    check("data_ok_idle", k, {31'd0, dok_v[k]}, 32'd0);
                    check("rdata_hold", k, rdata_v[k], last_rd[k]);
                end
            end
            if (live[k] || rst_v[k]) begin
                exp_ok = !rst_v[k] && !hold_v[k] && ((tl[k] - hd[k]) < 4);
                check("addr_ok", k, {31'd0, ok_v[k]}, {31'd0, exp_ok});
            end
            if (rst_v[k]) begin
                hd[k] = tl[k];
                last_rd[k] = 32'd0;
                last_due[k] = 0;
                live[k] = 1'b1;
            end else if (live[k] && req_v[k] && exp_ok) begin
                w = addr_v[k][11:2];
                if (wr_v[k]) begin
                    mdl_mem[k][w] = merge(mdl_mem[k][w], wdata_v[k], wstrb_v[k]);
                    dat = 32'd0;
                end else begin
                    dat = mdl_mem[k][w];
                end
                dd = cyc + lat_of(k);
                if (dd <= last_due[k]) dd = last_due[k] + 1;
                q_due[k][tl[k] % 64] = dd;
                q_dat[k][tl[k] % 64] = dat;
                tl[k]++;
                last_due[k] = dd;
            end
        end
    end

    task automatic do_txn(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        int t;
        int acc;
        @(posedge clk); #1;
        req_v[k] = 1'b1; wr_v[k] = w; addr_v[k] = a; wstrb_v[k] = s; wdata_v[k] = d;
        t = 0;
        @(negedge clk);
        while (!ok_v[k] && t < 50) begin @(negedge clk); t++; end
        acc = cyc;
        @(posedge clk); #1;
        req_v[k] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!dok_v[k] && t < 50) begin @(negedge clk); t++; end
        lat = cyc - acc;
        rd  = rdata_v[k];
    endtask

    task automatic stream(input int k, input int n, input logic w, input logic [31:0] base,
                          input int hold_at, output int stalls);
        int i;
        int t;
        i = 0; t = 0; stalls = 0;
        while (i < n && t < 200) begin
            @(posedge clk); #1;
            req_v[k] = 1'b1; wr_v[k] = w; wstrb_v[k] = 4'hF;
            addr_v[k] = base + 32'(4 * i); wdata_v[k] = pat(base + 32'(4 * i));
            hold_v[k] = (t >= hold_at) && (t < hold_at + 3);
            @(negedge clk);
            if (ok_v[k]) begin
                if (i < 16) acc_log[i] = cyc;
                i++;
            end else begin
                stalls++;
            end
            t++;
        end
        check("stream_done", k, 32'(i), 32'(n));
        @(posedge clk); #1;
        req_v[k] = 1'b0; hold_v[k] = 1'b0;
    endtask

    task automatic rand_run(input int k, input int n);
        logic pend;
        pend = 1'b0;
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            rst_v[k] = 1'b0;
            if (!pend) begin
                if ($urandom_range(0, 99) == 0) begin
                    rst_v[k] = 1'b1;
                    req_v[k] = 1'b0;
                end else begin
                    req_v[k]   = ($urandom_range(0, 3) != 0);
                    wr_v[k]    = ($urandom_range(0, 2) == 0);
                    size_v[k]  = 2'($urandom_range(0, 3));
                    addr_v[k]  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
                    wstrb_v[k] = 4'($urandom_range(0, 15));
                    wdata_v[k] = $urandom;
                end
            end
            hold_v[k] = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            pend = req_v[k] && !ok_v[k];
        end
        @(posedge clk); #1;
        req_v[k] = 1'b0; hold_v[k] = 1'b0; rst_v[k] = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [11];
        logic [31:0] rd;
        int          lat;
        int          st;
        int          d0;

        tbl[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[1]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0040, 4'hF, 32'h1122_3344, 32'h0000_0000};
        tbl[3]  = '{1'b1, 32'h0000_0040, 4'h5, 32'hAABB_CCDD, 32'h0000_0000};
        tbl[4]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0000_0000, 32'h11BB_33DD};
        tbl[5]  = '{1'b1, 32'h0000_0040, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[6]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0000_0000, 32'h11BB_33DD};
        tbl[7]  = '{1'b0, 32'h0000_1040, 4'h0, 32'h0000_0000, 32'h11BB_33DD};
        tbl[8]  = '{1'b0, 32'h0000_0042, 4'h0, 32'h0000_0000, 32'h11BB_33DD};
        tbl[9]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h1234_5678, 32'h0000_0000};
        tbl[10] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0000_0000, 32'h1234_5678};

        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; req_v[k] = 1'b0; wr_v[k] = 1'b0; size_v[k] = 2'd2;
            addr_v[k] = '0; wstrb_v[k] = '0; wdata_v[k] = '0; hold_v[k] = 1'b0;
            hd[k] = 0; tl[k] = 0; last_due[k] = 0; last_rd[k] = '0;
            live[k] = 1'b0; dok_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
        @(negedge clk);
        check("reset_data_ok", 0, {31'd0, dok_v[0]}, 32'd0);
        check("reset_rdata", 0, rdata_v[0], 32'd0);

        // Single transactions on LAT=2: data and latency.
        for (int i = 0; i < 11; i++) begin
            do_txn(0, tbl[i].w, tbl[i].addr, tbl[i].strb, tbl[i].wdata, rd, lat);
            check("tbl_rdata", i, rd, tbl[i].exp);
            check("tbl_lat", i, 32'(lat), 32'd2);
        end

        // Back-to-back on LAT=1: no stalls, one data_ok per access.
        @(posedge clk); #1;
        d0 = dok_cnt[1];
        stream(1, 8, 1'b1, 32'h0, 1000, st);
        check("b2b_wr_stalls", 1, 32'(st), 32'd0);
        stream(1, 8, 1'b0, 32'h0, 1000, st);
        check("b2b_rd_stalls", 1, 32'(st), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_dok_count", 1, 32'(dok_cnt[1] - d0), 32'd16);

        // Full queue on LAT=8, DEPTH=4.
        d0 = dok_cnt[2];
        stream(2, 6, 1'b1, 32'h0, 1000, st);
        check("full_4th_accept", 2, 32'(acc_log[3] - acc_log[0]), 32'd3);
        check("full_5th_accept", 2, 32'(acc_log[4] - acc_log[0]), 32'd8);
        check("full_6th_accept", 2, 32'(acc_log[5] - acc_log[0]), 32'd9);
        check("full_stalls", 2, 32'(st), 32'd4);
        repeat (20) @(posedge clk);
        #1;
        check("full_dok_count", 2, 32'(dok_cnt[2] - d0), 32'd6);

        // addr_hold for 3 cycles mid-stream on LAT=2.
        stream(0, 8, 1'b1, 32'h80, 2, st);
        check("hold_stalls", 0, 32'(st), 32'd3);

        // Reset with 3 outstanding reads on LAT=8.
        stream(2, 3, 1'b0, 32'h0, 1000, st);
        rst_v[2] = 1'b1;
        @(posedge clk); #1;
        rst_v[2] = 1'b0;
        d0 = dok_cnt[2];
        @(negedge clk);
        check("rst_addr_ok_resume", 2, {31'd0, ok_v[2]}, 32'd1);
        check("rst_rdata_zero", 2, rdata_v[2], 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_dok", 2, 32'(dok_cnt[2] - d0), 32'd0);
        do_txn(2, 1'b0, 32'h4, 4'h0, 32'h0, rd, lat);
        check("rst_mem_kept", 2, rd, pat(32'h4));
        check("rst_read_lat", 2, 32'(lat), 32'd8);

        // Randomized traffic over a pre-written 16-word region on all instances.
        for (int k = 0; k < 3; k++) stream(k, 16, 1'b1, 32'h0, 1000, st);
        repeat (12) @(posedge clk);
        fork
            rand_run(0, 300);
            rand_run(1, 300);
            rand_run(2, 300);
        join
        repeat (30) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
